// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Definitions shared by the instruction-fetch stage and its sub-modules.
//
//   RESET_PC    : architectural PC value after reset.
//   NOP_INSTR   : value held in the instruction register when no fetched word
//                 is present (after reset, and on an alignment exception).
//   ifu_state_t : fetch sequencer states.
//                   IDLE - one cycle after reset release, nothing issued.
//                   REQ  - request offered to instruction memory.
//                   WAIT - request granted, response outstanding.
//                   HOLD - fetched word presented to decode.
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

endpackage : cpu_defs

// File: rtl/ifu_out_reg.sv
// ---------------------------------------------------------------------------
// ifu_out_reg
//   Holding register for the word presented to decode. A load captures a new
//   PC/instruction pair and raises valid; a clear drops valid only, the data
//   fields keep their last value (they are only meaningful while valid=1).
//   Load wins over clear.
//
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     load             capture ld_pc/ld_instr, set valid
//     clear            drop valid
//     ld_pc, ld_instr  data to capture
//     valid            word available to decode
//     pc               PC of the held word
//     instr            held instruction word
// ---------------------------------------------------------------------------
module ifu_out_reg
    import cpu_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ld_pc,
    input  logic [31:0]       ld_instr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= ld_pc;
            instr <= ld_instr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule : ifu_out_reg

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Instruction-fetch stage. Owns the architectural PC, issues one word fetch
//   at a time over a req/gnt/rvalid handshake and presents the fetched word to
//   decode over valid/ready. A redirect loads the PC from npc_in in any state
//   and discards whatever fetch is in flight or being held.
//
//   Sequence: IDLE -> REQ -> WAIT -> HOLD -> REQ ...
//     The request address is latched when REQ is entered, so req/addr stay
//     stable until gnt even if a redirect arrives meanwhile; the granted
//     response is then dropped via the kill flag.
//
//   Build option:
//     IFU_ALIGN_CHK_EN  defined   : a misaligned PC issues no request; the
//                                   stage presents an exception word instead
//                                   (if_exc=1, if_instr=NOP, if_pc=pc) and
//                                   stays there until redirected.
//                       undefined : if_exc tied 0, fetch address word-aligned.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     npc_in                      next PC (pc+4, or target when redirecting)
//     redirect_valid              npc_in is a non-sequential target
//     pc                          current PC, to the next-PC unit
//     imem_req/addr/gnt           fetch request handshake
//     imem_rvalid/rdata           fetch response
//     if_valid/if_ready           handshake to decode
//     if_pc, if_pc4, if_instr     presented word, its PC and PC+4
//     if_exc                      fetch address exception
// ---------------------------------------------------------------------------
module ifu_fetch
    import cpu_defs::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_defs::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] npc_in,
    input  logic              redirect_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    output logic [31:0]       if_instr,
    output logic              if_exc
);

    ifu_state_t        state;
    logic              kill;      // granted response must be discarded
    logic [ADDR_W-1:0] req_addr;  // address latched on entry to REQ

    // PC the next request will use: a redirect overrides the current PC.
    logic [ADDR_W-1:0] next_fetch_pc;
    assign next_fetch_pc = redirect_valid ? npc_in : pc;

    // Address actually placed on the bus for a given PC.
    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] a);
`ifdef IFU_ALIGN_CHK_EN
        return a;
`else
        return {a[ADDR_W-1:2], 2'b00};
`endif
    endfunction

`ifdef IFU_ALIGN_CHK_EN
    logic exc_q;
    logic misaligned;
    assign misaligned = (req_addr[1:0] != 2'b00);
    assign imem_req   = (state == REQ) && !misaligned;
    assign if_exc     = exc_q;
`else
    assign imem_req   = (state == REQ);
    assign if_exc     = 1'b0;
`endif

    assign imem_addr = req_addr;
    assign if_pc4    = if_pc + ADDR_W'(4);

    // -----------------------------------------------------------------------
    // Output-register control
    // -----------------------------------------------------------------------
    logic              out_load;
    logic              out_clear;
    logic [ADDR_W-1:0] out_ld_pc;
    logic [31:0]       out_ld_instr;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        out_load     = 1'b0;
        out_clear    = 1'b0;
        out_ld_pc    = pc;
        out_ld_instr = imem_rdata;
        case (state)
`ifdef IFU_ALIGN_CHK_EN
            REQ: begin
                if (misaligned && !redirect_valid) begin
                    out_load     = 1'b1;
                    out_ld_instr = NOP_INSTR;
                end
            end
`endif
            WAIT: begin
                // Redirect has priority over capture.
                if (imem_rvalid && !kill && !redirect_valid)
                    out_load = 1'b1;
            end
            HOLD: begin
                if (redirect_valid || if_ready)
                    out_clear = 1'b1;
            end
            default: ;
        endcase
    end

    ifu_out_reg #(
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (out_load),
        .clear    (out_clear),
        .ld_pc    (out_ld_pc),
        .ld_instr (out_ld_instr),
        .valid    (if_valid),
        .pc       (if_pc),
        .instr    (if_instr)
    );

    // -----------------------------------------------------------------------
    // Fetch sequencer, PC and kill flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            req_addr <= fetch_addr(RESET_PC);
`ifdef IFU_ALIGN_CHK_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            // A redirect loads the PC in every state; the sequential advance
            // below only happens on a capture, which excludes redirect.
            if (redirect_valid)
                pc <= npc_in;

            case (state)
                IDLE: begin
                    state    <= REQ;
                    req_addr <= fetch_addr(next_fetch_pc);
                end

                REQ: begin
`ifdef IFU_ALIGN_CHK_EN
                    if (misaligned) begin
                        // Nothing was issued, so a redirect simply retargets.
                        if (redirect_valid)
                            req_addr <= fetch_addr(npc_in);
                        else begin
                            state <= HOLD;
                            exc_q <= 1'b1;
                        end
                    end else
`endif
                    begin
                        // The offered request must still complete; mark its
                        // response for discard.
                        if (redirect_valid)
                            kill <= 1'b1;
                        if (imem_gnt)
                            state <= WAIT;
                    end
                end

                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect_valid) begin
                            kill     <= 1'b0;
                            state    <= REQ;
                            req_addr <= fetch_addr(next_fetch_pc);
                        end else begin
                            pc    <= npc_in;
                            state <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end

                HOLD: begin
                    if (redirect_valid || if_ready) begin
                        state    <= REQ;
                        req_addr <= fetch_addr(next_fetch_pc);
`ifdef IFU_ALIGN_CHK_EN
                        exc_q    <= 1'b0;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : ifu_fetch
